// File: rtl/regs_file_multiport_if.sv
// Bus bundle for the multiport register file: decode-stage read ports plus the writeback write port.
// master = pipeline side, slave = register file.
interface regs_file_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     ready;
  logic                     wr_drop;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, ready, wr_drop
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, ready, wr_drop
  );
endinterface

// File: rtl/regs_file_multiport.sv
// MIPS GPR file: NUM_RD combinational read ports, one write port, reg[i]=i init sequencer, r0 reads zero.
// Define REGS_FILE_BYPASS_EN for write-first reads in RUN; otherwise reads are read-first.
//
// state | meaning
// RST   | held in reset, counter cleared, file not ready
// INIT  | writing reg[cnt] = cnt, one register per cycle
// RUN   | ready; writeback port owns the array
module regs_file_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic                  clk,
  input logic                  reset,
  regs_file_multiport_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                run_wr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      ST_RUN: state_d = ST_RUN;
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Writes to r0 are discarded quietly; writes before ready are reported via wr_drop.
  assign run_wr = (state_q == ST_RUN) && bus.wr_en && (bus.wr_addr != '0);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    wr_drop_d = bus.wr_en && (state_q != ST_RUN);
    unique case (state_q)
      ST_INIT: begin
        mem_we    = reset;
        mem_waddr = cnt_q;
        mem_wdata = DATA_W'(cnt_q);
      end
      ST_RUN: begin
        mem_we    = run_wr && reset;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.ready   = (state_q == ST_RUN);
  assign bus.wr_drop = wr_drop_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp;

    assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

`ifdef REGS_FILE_BYPASS_EN
    assign byp = run_wr && (bus.wr_addr == ra);
`else
    assign byp = 1'b0;
`endif

    assign bus.rd_data[k*DATA_W +: DATA_W] =
      (!bus.ready || (ra == '0)) ? '0 :
      byp                        ? bus.wr_data :
                                   mem_q[ra];
  end

endmodule

// File: tb/tb_regs_file_multiport.sv
// Directed bench for regs_file_multiport: a default 32x32/2-port instance and a 16-bit/8-deep/4-port instance.
module tb_regs_file_multiport;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regs_file_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regs_file_multiport_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) bus_b ();

  regs_file_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  regs_file_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.wr_en   = 1'b0;
    bus_a.wr_addr = '0;
    bus_a.wr_data = '0;
    bus_a.rd_addr = '0;
    bus_b.wr_en   = 1'b0;
    bus_b.wr_addr = '0;
    bus_b.wr_data = '0;
    bus_b.rd_addr = '0;
  endtask

  // Counts posedges until each instance is ready; 0 means the bound expired.
  task automatic wait_ready(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (bus_b.ready === 1'b1 && nb == 0) nb = n;
      if (bus_a.ready === 1'b1 && na == 0) na = n;
      if (na != 0 && nb != 0) break;
    end
  endtask

  task automatic test_reset();
    int na, nb;
    reset = 1'b0;
    idle();
    bus_a.rd_addr = {5'd31, 5'd5};
    bus_b.rd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    repeat (3) step();
    checks++;
    if (bus_a.ready !== 1'b0 || bus_a.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags_a: ready=%b wr_drop=%b required 0/0", bus_a.ready, bus_a.wr_drop);
    end
    checks++;
    if (bus_a.rd_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_rd_data_a: got %h required 0", bus_a.rd_data);
    end
    checks++;
    if (bus_b.ready !== 1'b0 || bus_b.rd_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_b: ready=%b rd_data=%h required 0/0", bus_b.ready, bus_b.rd_data);
    end
    reset = 1'b1;
    wait_ready(na, nb);
    checks++;
    if (na != 33) begin
      errors++;
      $display("FAIL ready_latency_a: got %0d cycles required 33", na);
    end
    checks++;
    if (nb != 9) begin
      errors++;
      $display("FAIL ready_latency_b: got %0d cycles required 9", nb);
    end
  endtask

  task automatic test_init_read();
    logic [31:0] exp32;
    logic [15:0] exp16;
    checks++;
    if (bus_a.rd_data !== {32'd31, 32'd5}) begin
      errors++;
      $display("FAIL init_read_5_31: got %h required %h", bus_a.rd_data, {32'd31, 32'd5});
    end
    checks++;
    if (bus_b.rd_data !== {16'd3, 16'd2, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL init_read_b_0123: got %h required %h", bus_b.rd_data, {16'd3, 16'd2, 16'd1, 16'd0});
    end
    for (int i = 0; i < 32; i++) begin
      bus_a.rd_addr = {5'd0, 5'(i)};
      #1;
      exp32 = 32'(i);
      checks++;
      if (bus_a.rd_data !== {32'd0, exp32}) begin
        errors++;
        $display("FAIL init_read_a_reg%0d: got %h required %h", i, bus_a.rd_data, {32'd0, exp32});
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus_b.rd_addr = {4{3'(i)}};
      #1;
      exp16 = (i == 0) ? 16'd0 : 16'(i);
      checks++;
      if (bus_b.rd_data !== {4{exp16}}) begin
        errors++;
        $display("FAIL init_read_b_reg%0d: got %h required %h", i, bus_b.rd_data, {4{exp16}});
      end
    end
    bus_b.rd_addr = '0;
  endtask

  task automatic test_write();
    logic [63:0] exp;
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd7;
    bus_a.wr_data = 32'hDEADBEEF;
    bus_a.rd_addr = {5'd7, 5'd7};
    #1;
`ifdef REGS_FILE_BYPASS_EN
    exp = {2{32'hDEADBEEF}};
`else
    exp = {2{32'd7}};
`endif
    checks++;
    if (bus_a.rd_data !== exp) begin
      errors++;
      $display("FAIL write7_same_cycle: got %h required %h", bus_a.rd_data, exp);
    end
    step();
    bus_a.wr_en = 1'b0;
    #1;
    checks++;
    if (bus_a.rd_data !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL write7_next_cycle: got %h required %h", bus_a.rd_data, {2{32'hDEADBEEF}});
    end
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd0;
    bus_a.wr_data = 32'hFFFFFFFF;
    bus_a.rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (bus_a.rd_data !== 64'd0) begin
      errors++;
      $display("FAIL write0_same_cycle: got %h required 0", bus_a.rd_data);
    end
    step();
    bus_a.wr_en = 1'b0;
    #1;
    checks++;
    if (bus_a.rd_data !== 64'd0 || bus_a.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL write0_discard: rd_data=%h wr_drop=%b required 0/0", bus_a.rd_data, bus_a.wr_drop);
    end
    bus_a.rd_addr = {5'd8, 5'd6};
    #1;
    checks++;
    if (bus_a.rd_data !== {32'd8, 32'd6}) begin
      errors++;
      $display("FAIL neighbours_untouched: got %h required %h", bus_a.rd_data, {32'd8, 32'd6});
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd9;
    bus_a.wr_data = 32'h0000A5A5;
    bus_a.rd_addr = {5'd10, 5'd9};
    #1;
`ifdef REGS_FILE_BYPASS_EN
    exp = 32'h0000A5A5;
`else
    exp = 32'd9;
`endif
    checks++;
    if (bus_a.rd_data !== {32'd10, exp}) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h required %h", bus_a.rd_data, {32'd10, exp});
    end
    step();
    bus_a.wr_en = 1'b0;
    #1;
    checks++;
    if (bus_a.rd_data !== {32'd10, 32'h0000A5A5}) begin
      errors++;
      $display("FAIL bypass_next_cycle: got %h required %h", bus_a.rd_data, {32'd10, 32'h0000A5A5});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd1;
    bus_a.wr_data = 32'h11;
    step();
    bus_a.wr_addr = 5'd2;
    bus_a.wr_data = 32'h22;
    step();
    bus_a.wr_addr = 5'd30;
    bus_a.wr_data = 32'h30303030;
    step();
    bus_a.wr_en   = 1'b0;
    bus_a.rd_addr = {5'd2, 5'd1};
    #1;
    checks++;
    if (bus_a.rd_data !== {32'h22, 32'h11}) begin
      errors++;
      $display("FAIL b2b_regs_1_2: got %h required %h", bus_a.rd_data, {32'h22, 32'h11});
    end
    bus_a.rd_addr = {5'd30, 5'd30};
    #1;
    checks++;
    if (bus_a.rd_data !== {2{32'h30303030}}) begin
      errors++;
      $display("FAIL b2b_reg30: got %h required %h", bus_a.rd_data, {2{32'h30303030}});
    end
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = 3'd5;
    bus_b.wr_data = 16'hBEEF;
    bus_b.rd_addr = {3'd5, 3'd5, 3'd5, 3'd0};
    #1;
`ifdef REGS_FILE_BYPASS_EN
    exp = {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0};
`else
    exp = {16'd5, 16'd5, 16'd5, 16'h0};
`endif
    checks++;
    if (bus_b.rd_data !== exp) begin
      errors++;
      $display("FAIL b_shared_same_cycle: got %h required %h", bus_b.rd_data, exp);
    end
    step();
    bus_b.wr_en = 1'b0;
    #1;
    checks++;
    if (bus_b.rd_data !== {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0}) begin
      errors++;
      $display("FAIL b_shared_next_cycle: got %h required %h", bus_b.rd_data, {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0});
    end
  endtask

  task automatic test_wr_drop();
    int na, nb;
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (5) step();
    bus_a.rd_addr = {5'd5, 5'd3};
    #1;
    checks++;
    if (bus_a.ready !== 1'b0 || bus_a.rd_data !== 64'd0) begin
      errors++;
      $display("FAIL init_reads_zero: ready=%b rd_data=%h required 0/0", bus_a.ready, bus_a.rd_data);
    end
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd3;
    bus_a.wr_data = 32'h55;
    step();
    bus_a.wr_en = 1'b0;
    checks++;
    if (bus_a.wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL wr_drop_pulse: got %b required 1", bus_a.wr_drop);
    end
    step();
    checks++;
    if (bus_a.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL wr_drop_single_cycle: got %b required 0", bus_a.wr_drop);
    end
    wait_ready(na, nb);
    checks++;
    if (na != 26) begin
      errors++;
      $display("FAIL wr_drop_ready_latency: got %0d cycles required 26", na);
    end
    checks++;
    if (bus_a.rd_data !== {32'd5, 32'd3}) begin
      errors++;
      $display("FAIL dropped_write_ignored: got %h required %h", bus_a.rd_data, {32'd5, 32'd3});
    end
  endtask

  task automatic test_reset_mid();
    int na, nb;
    bus_a.rd_addr = {5'd31, 5'd5};
    reset = 1'b0;
    step();
    checks++;
    if (bus_a.ready !== 1'b0 || bus_a.rd_data !== 64'd0 || bus_b.ready !== 1'b0) begin
      errors++;
      $display("FAIL run_reset: ready_a=%b rd_data=%h ready_b=%b required 0/0/0", bus_a.ready, bus_a.rd_data, bus_b.ready);
    end
    reset = 1'b1;
    repeat (11) step();
    checks++;
    if (bus_a.ready !== 1'b0) begin
      errors++;
      $display("FAIL init_cycle10_not_ready: got %b required 0", bus_a.ready);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_ready(na, nb);
    checks++;
    if (na != 33) begin
      errors++;
      $display("FAIL restart_latency_a: got %0d cycles required 33", na);
    end
    checks++;
    if (nb != 9) begin
      errors++;
      $display("FAIL restart_latency_b: got %0d cycles required 9", nb);
    end
    bus_a.rd_addr = {5'd9, 5'd7};
    #1;
    checks++;
    if (bus_a.rd_data !== {32'd9, 32'd7}) begin
      errors++;
      $display("FAIL reinit_contents: got %h required %h", bus_a.rd_data, {32'd9, 32'd7});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_read();
    test_write();
    test_bypass();
    test_back_to_back();
    test_wr_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
